lif_neuron: RTL and testbench
=============================

# lif_neuron

Leaky integrate-and-fire neuron: the receiving end of the synapse path. It accumulates the gated weight currents that synapses emit, applies leak and a threshold once per timestep, and emits the spike that drives downstream synapses' `spike_in`. It sits between a layer's synapse outputs (summed or presented serially) and the next layer's synapse inputs.

## Interface
Parameters:
- `VW`, 16: width of the incoming synaptic current (signed, two's complement).
- `MW`, 24: membrane potential width (signed). Must satisfy MW > VW.
- `THRESH`, 1000: firing threshold (signed, MW bits). Fire when membrane >= THRESH.
- `V_RESET`, 0: membrane value loaded on fire.
- `LEAK_SHIFT`, 4: leak amount is membrane >>> LEAK_SHIFT (arithmetic).
- `REFRAC`, 2: refractory length in timesteps; 0 disables refractory.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `v_in` carries one synaptic current this cycle.
- `v_in`  in  VW  signed synaptic current (synapse `v_out`).
- `step`  in  1  end-of-timestep strobe, one cycle.
- `spike_out`  out  1  registered one-cycle spike pulse.
- `membrane`  out  MW  current membrane potential (registered).
- `refrac_busy`  out  1  high while in REFRACT state.

Clocking and reset: one clock; reset is synchronous and active-low.

## Operation
- States: INTEG, REFRACT. Reset: state INTEG, `membrane`=0, `spike_out`=0, `refrac_busy`=0, refractory counter=0.
- INTEG, `in_valid`=1, `step`=0: membrane <= sat(membrane + sext(v_in)).
- INTEG, `step`=1: sum = sat(membrane + (in_valid ? sext(v_in) : 0)); leaked = sat(sum - (sum >>> LEAK_SHIFT)).
  - leaked >= THRESH: membrane <= V_RESET, spike_out <= 1, counter <= REFRAC, state <= REFRACT if REFRAC>0 else stay INTEG.
  - else membrane <= leaked.
- REFRACT: `in_valid` samples are dropped (membrane holds V_RESET). On `step`: counter <= counter-1; if counter==1, state <= INTEG. The current with a step in REFRACT is also dropped.
- Saturation: all adds/subtracts clamp to [-2^(MW-1), 2^(MW-1)-1]; no wrap-around ever.
- Threshold compare is signed.
- `spike_out` deasserts the cycle after it asserts; it is never high two consecutive cycles, even with back-to-back `step` and REFRAC=0.

## Timing
- Integration latency: `membrane` reflects an `in_valid` sample one cycle later.
- Spike latency: `spike_out` high exactly the cycle after the `step` cycle that crossed threshold; `membrane`=V_RESET and `refrac_busy`=1 same cycle.
- `in_valid` and `step` in the same cycle: input included before leak and threshold.
- `refrac_busy` falls the cycle after the REFRAC-th step following the fire; the next `in_valid` in that cycle is accepted.
- No backpressure: block accepts every cycle; `in_valid` requires no handshake.
- `rst_n` low in any state (including mid-refractory or the spike cycle) restores reset values next edge; reset dominates `step`/`in_valid`.

## Configuration
- `LIF_LEAK_EN` defined: leak as specified (leaked = sum - (sum >>> LEAK_SHIFT)).
- Not defined: no leak logic; leaked = sum (pure integrate-and-fire); LEAK_SHIFT ignored.

## Test plan
- Reset: hold rst_n=0 two cycles with in_valid=1, v_in=500, step=1 -> membrane=0, spike_out=0, refrac_busy=0.
- Integrate+leak (LIF_LEAK_EN): three samples v_in=300, then step -> membrane 900 then 900-56=844, no spike.
- Simultaneous: from 844, in_valid=1, v_in=200 with step -> 1044-65=979, no spike; with LIF_LEAK_EN undefined -> 1044 >= 1000, spike_out one cycle, membrane=0.
- Fire+refractory: from 0, v_in=600 twice, step -> 1200-75=1125, spike_out pulse, refrac_busy=1; v_in=2000 during REFRACT leaves membrane 0; after 2 steps refrac_busy=0; then v_in=2000, step -> spike.
- Saturation: 257 samples v_in=32767, no step -> membrane=8388607 (not wrapped); 257 samples of -32768 from 0 -> -8388608.
- Reset mid-refractory: fire, then rst_n=0 one cycle after spike -> refrac_busy=0, state INTEG; next v_in=100 accepted, membrane=100.

Source files
------------

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - leaky integrate-and-fire neuron with refractory period
// Leak stage is present only when LIF_LEAK_EN is defined; otherwise pure integrate-and-fire.
module lif_neuron #(
  parameter int                      VW         = 16,
  parameter int                      MW         = 24,
  parameter logic signed [MW-1:0]    THRESH     = 1000,
  parameter logic signed [MW-1:0]    V_RESET    = 0,
  parameter int                      LEAK_SHIFT = 4,
  parameter int                      REFRAC     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [VW-1:0] v_in,
  input  logic                 step,
  output logic                 spike_out,
  output logic signed [MW-1:0] membrane,
  output logic                 refrac_busy
);

  localparam logic [0:0] ST_INTEG   = 1'b0;
  localparam logic [0:0] ST_REFRACT = 1'b1;
  localparam int CW = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
  localparam logic [CW-1:0] REFRAC_C = CW'(REFRAC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [0:0]           state_q, state_d;
  logic signed [MW-1:0] mem_q, mem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 spike_q, spike_d;

  logic signed [MW:0]   vin_ext;
  logic signed [MW:0]   mem_ext;
  logic signed [MW:0]   sum_ext;
  logic signed [MW-1:0] sum_sat;
  logic signed [MW-1:0] leaked;
  logic                 fire;

  // One guard bit: overflow shows as disagreement between the top two bits.
  function automatic logic signed [MW-1:0] sat(input logic signed [MW:0] x);
    if (x[MW] != x[MW-1])
      return x[MW] ? $signed({1'b1, {(MW-1){1'b0}}}) : $signed({1'b0, {(MW-1){1'b1}}});
    else
      return x[MW-1:0];
  endfunction

  assign vin_ext = $signed({{(MW+1-VW){v_in[VW-1]}}, v_in});
  assign mem_ext = $signed({mem_q[MW-1], mem_q});
  assign sum_ext = mem_ext + (in_valid ? vin_ext : '0);
  assign sum_sat = sat(sum_ext);

`ifdef LIF_LEAK_EN
  logic signed [MW:0] sum_w;
  assign sum_w  = $signed({sum_sat[MW-1], sum_sat});
  assign leaked = sat(sum_w - (sum_w >>> LEAK_SHIFT));
`else
  logic unused_leak_shift;
  assign unused_leak_shift = ^LEAK_SHIFT;
  assign leaked = sum_sat;
`endif

  // A fire is held off while the previous spike is still on the output,
  // so back-to-back steps with REFRAC=0 never produce a two-cycle pulse.
  assign fire = (leaked >= THRESH) && !spike_q;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    case (state_q)
      ST_INTEG: begin
        if (step) begin
          if (fire) begin
            mem_d   = V_RESET;
            spike_d = 1'b1;
            cnt_d   = REFRAC_C;
            if (REFRAC > 0) state_d = ST_REFRACT;
          end else begin
            mem_d = leaked;
          end
        end else if (in_valid) begin
          mem_d = sum_sat;
        end
      end
      default: begin
        if (step) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_INTEG;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INTEG;
      mem_q   <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  assign spike_out   = spike_q;
  assign membrane    = mem_q;
  assign refrac_busy = (state_q == ST_REFRACT);

endmodule

// File: tb/tb_lif_neuron.sv
// tb/tb_lif_neuron.sv - directed self-checking bench for lif_neuron
// Expected values follow LIF_LEAK_EN the same way the design does.
module tb_lif_neuron;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] v_in;
  logic               step;
  logic               spike_out;
  logic signed [23:0] membrane;
  logic               refrac_busy;

  int checks   = 0;
  int failures = 0;

  lif_neuron dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .v_in        (v_in),
    .step        (step),
    .spike_out   (spike_out),
    .membrane    (membrane),
    .refrac_busy (refrac_busy)
  );

  always #5 clk = ~clk;

`ifdef LIF_LEAK_EN
  localparam bit LEAK = 1'b1;
`else
  localparam bit LEAK = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input int v, input logic st);
    in_valid = iv;
    v_in     = 16'(v);
    step     = st;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset dominates active inputs
    rst_n = 1'b0;
    drive(1'b1, 500, 1'b1);
    tick();
    tick();
    check("rst_membrane", membrane, 0);
    check("rst_spike", spike_out, 0);
    check("rst_busy", refrac_busy, 0);

    // Integrate three samples, then a leak step
    rst_n = 1'b1;
    drive(1'b1, 300, 1'b0);
    tick();
    check("int_one_cycle", membrane, 300);
    tick();
    tick();
    check("int_900", membrane, 900);
    drive(1'b0, 0, 1'b1);
    tick();
    check("leak_step", membrane, LEAK ? 844 : 900);
    check("leak_no_spike", spike_out, 0);

    // Input together with step: included before leak/threshold
    drive(1'b1, 200, 1'b1);
    tick();
    check("simul_membrane", membrane, LEAK ? 979 : 0);
    check("simul_spike", spike_out, LEAK ? 0 : 1);
    check("simul_busy", refrac_busy, LEAK ? 0 : 1);
    drive(1'b0, 0, 1'b0);
    tick();
    check("simul_spike_drop", spike_out, 0);

    // Fire and refractory
    do_reset();
    drive(1'b1, 600, 1'b0);
    tick();
    tick();
    drive(1'b0, 0, 1'b1);
    tick();
    check("fire_spike", spike_out, 1);
    check("fire_membrane", membrane, 0);
    check("fire_busy", refrac_busy, 1);
    drive(1'b1, 2000, 1'b0);
    tick();
    check("refr_spike_low", spike_out, 0);
    check("refr_drop_input", membrane, 0);
    drive(1'b1, 2000, 1'b1);
    tick();
    check("refr_step1_busy", refrac_busy, 1);
    check("refr_step1_mem", membrane, 0);
    drive(1'b0, 0, 1'b1);
    tick();
    check("refr_step2_busy", refrac_busy, 0);
    drive(1'b1, 2000, 1'b1);
    tick();
    check("refire_spike", spike_out, 1);
    check("refire_membrane", membrane, 0);
    drive(1'b0, 0, 1'b0);
    tick();
    check("refire_spike_low", spike_out, 0);

    // Threshold boundary: one below, then exactly at
    do_reset();
    drive(1'b1, LEAK ? 1065 : 999, 1'b1);
    tick();
    check("below_thresh_spike", spike_out, 0);
    check("below_thresh_mem", membrane, 999);
    do_reset();
    drive(1'b1, LEAK ? 1066 : 1000, 1'b1);
    tick();
    check("at_thresh_spike", spike_out, 1);
    check("at_thresh_mem", membrane, 0);

    // Positive and negative saturation
    do_reset();
    drive(1'b1, 32767, 1'b0);
    for (int i = 0; i < 256; i++) tick();
    check("sat_pos_256", membrane, 8388352);
    tick();
    check("sat_pos_257", membrane, 8388607);
    tick();
    check("sat_pos_hold", membrane, 8388607);
    do_reset();
    drive(1'b1, -32768, 1'b0);
    for (int i = 0; i < 257; i++) tick();
    check("sat_neg_257", membrane, -8388608);

    // Reset in the spike cycle, mid-refractory
    do_reset();
    drive(1'b1, 600, 1'b0);
    tick();
    tick();
    drive(1'b0, 0, 1'b1);
    tick();
    check("mid_fire_busy", refrac_busy, 1);
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b0);
    tick();
    check("mid_rst_busy", refrac_busy, 0);
    check("mid_rst_spike", spike_out, 0);
    rst_n = 1'b1;
    drive(1'b1, 100, 1'b0);
    tick();
    check("mid_rst_accept", membrane, 100);

    drive(1'b0, 0, 1'b0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
